// File: rtl/cpu_traffic_gen.sv
// Per-CPU word source: tagged {cpu_index, seq} words over valid/ready,
// with LFSR-driven idle gaps and a sticky done flag.
module cpu_traffic_gen #(
  parameter int unsigned NUM_TRANSACTIONS = 1000,
  parameter int unsigned GAP_BITS = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_index,
  input  logic        data_rdy,
  output logic        data_vld,
  output logic [63:0] data,
  output logic        transactions_done
);

  localparam int unsigned GW = (GAP_BITS > 0) ? GAP_BITS : 1;
  localparam logic [31:0] LAST = 32'(NUM_TRANSACTIONS - 1);

  typedef enum logic [1:0] {
    GAP,
    SEND,
    DONE
  } state_t;

  state_t        state;
  logic [31:0]   seq;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   lfsr;
  logic          seeded;

  logic          xfer;
  logic [15:0]   seed_mix;
  logic [15:0]   seed;
  logic [15:0]   lfsr_nxt;
  logic [GW-1:0] gap_nxt;
  logic          gap_end;

  assign xfer     = data_vld & data_rdy;
  assign seed_mix = LFSR_SEED ^ cpu_index[15:0];
  assign seed     = (seed_mix == 16'h0) ? LFSR_SEED : seed_mix;
  assign lfsr_nxt = {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign gap_nxt  = (GAP_BITS == 0) ? '0 : lfsr[GW-1:0];

  // The counter holds the idle cycles still to spend; launching on 1
  // keeps a loaded gap of k at exactly k idle cycles.
  assign gap_end  = (gap_cnt <= GW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= GAP;
      seq               <= '0;
      gap_cnt           <= '0;
      lfsr              <= LFSR_SEED;
      seeded            <= 1'b0;
      data_vld          <= 1'b0;
      data              <= '0;
      transactions_done <= 1'b0;
    end else begin
      unique case (state)
        GAP: begin
          if (gap_end) begin
            state    <= SEND;
            data_vld <= 1'b1;
            data     <= {cpu_index, seq};
            gap_cnt  <= '0;
            if (!seeded) begin
              lfsr   <= seed;
              seeded <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        SEND: begin
          if (xfer) begin
            if (seq == LAST) begin
              state             <= DONE;
              data_vld          <= 1'b0;
              transactions_done <= 1'b1;
            end else begin
              seq  <= seq + 32'd1;
              lfsr <= lfsr_nxt;
              if (gap_nxt == '0) begin
                data <= {cpu_index, seq + 32'd1};
              end else begin
                gap_cnt  <= gap_nxt;
                data_vld <= 1'b0;
                state    <= GAP;
              end
            end
          end
        end
        DONE: begin
          data_vld <= 1'b0;
        end
        default: begin
          state <= GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// Randomized bench for cpu_traffic_gen: idle-gap/sequence model
// checked every cycle, plus literal pins on small configurations.
module tb_cpu_traffic_gen;

  localparam int unsigned N = 10;
  localparam int unsigned GB = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [31:0] idx = 32'd0;
  logic        rdy = 1'b0;
  logic        vld;
  logic        done;
  logic [63:0] data;

  logic [31:0] b_idx = 32'd5;
  logic [31:0] o_idx = 32'd9;
  logic        one = 1'b1;
  logic        b_vld, b_done, o_vld, o_done;
  logic [63:0] b_data, o_data;

  cpu_traffic_gen #(
    .NUM_TRANSACTIONS(N), .GAP_BITS(GB), .LFSR_SEED(SEED)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_index(idx), .data_rdy(rdy),
    .data_vld(vld), .data(data), .transactions_done(done)
  );

  cpu_traffic_gen #(
    .NUM_TRANSACTIONS(4), .GAP_BITS(0), .LFSR_SEED(SEED)
  ) u_b2b (
    .clk(clk), .rst_n(rst_n), .cpu_index(b_idx), .data_rdy(one),
    .data_vld(b_vld), .data(b_data), .transactions_done(b_done)
  );

  cpu_traffic_gen #(
    .NUM_TRANSACTIONS(1), .GAP_BITS(3), .LFSR_SEED(SEED)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .cpu_index(o_idx), .data_rdy(one),
    .data_vld(o_vld), .data(o_data), .transactions_done(o_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_idx, m_seq;
  logic [15:0] m_lfsr;
  logic [63:0] m_last;
  int          m_gap, m_idle;
  bit          m_wait, m_done, m_on;
  int          cyc;
  int          lit_mode;

  function automatic logic [15:0] lfsr_step(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    logic [15:0] s;
    s = SEED ^ idx[15:0];
    if (s == 16'h0) s = SEED;
    m_idx  = idx;
    m_seq  = 0;
    m_lfsr = s;
    m_last = 0;
    m_done = 0;
    m_wait = 1;
    m_idle = 0;
    m_gap  = 1;
    m_on   = 1;
  endtask

  task automatic model_check();
    if (m_done) begin
      chk("vld_after_done", 64'(vld), 64'd0);
      chk("done_sticky", 64'(done), 64'd1);
      chk("data_after_done", data, m_last);
    end else begin
      chk("done_early", 64'(done), 64'd0);
      if (!m_wait) begin
        chk("vld_hold", 64'(vld), 64'd1);
      end else if (vld) begin
        chk("gap_len", 64'(m_idle), 64'(m_gap));
        m_wait = 0;
      end else begin
        m_idle++;
        chk("gap_over", 64'(m_idle <= m_gap), 64'd1);
      end
      if (vld) chk("word", data, {m_idx, m_seq});
      if (vld && rdy) begin
        m_last = {m_idx, m_seq};
        if (m_seq == 32'(N - 1)) begin
          m_done = 1;
        end else begin
          m_seq++;
          m_gap  = int'(m_lfsr[GB-1:0]);
          m_lfsr = lfsr_step(m_lfsr);
          m_wait = (m_gap != 0);
          m_idle = 0;
        end
      end
    end
  endtask

  task automatic lit_check();
    if (lit_mode == 1) begin
      if (cyc == 0) begin
        chk("b2b_idle0", 64'(b_vld), 64'd0);
        chk("one_idle0", 64'(o_vld), 64'd0);
      end else if (cyc <= 4) begin
        chk("b2b_vld", 64'(b_vld), 64'd1);
        chk("b2b_data", b_data, {32'd5, 32'(cyc - 1)});
        chk("b2b_done0", 64'(b_done), 64'd0);
      end else if (cyc <= 8) begin
        chk("b2b_vld_end", 64'(b_vld), 64'd0);
        chk("b2b_done", 64'(b_done), 64'd1);
        chk("b2b_last", b_data, {32'd5, 32'd3});
      end
      if (cyc == 1) begin
        chk("one_vld", 64'(o_vld), 64'd1);
        chk("one_data", o_data, {32'd9, 32'd0});
        chk("one_done0", 64'(o_done), 64'd0);
      end else if (cyc >= 2 && cyc <= 8) begin
        chk("one_vld_end", 64'(o_vld), 64'd0);
        chk("one_done", 64'(o_done), 64'd1);
        chk("one_last", o_data, {32'd9, 32'd0});
      end
    end else if (lit_mode == 2) begin
      if (cyc == 1) chk("i2_w0", data, {32'd2, 32'd0});
      if (cyc >= 2 && cyc <= 4) chk("i2_gap", 64'(vld), 64'd0);
      if (cyc == 5) begin
        chk("i2_vld1", 64'(vld), 64'd1);
        chk("i2_w1", data, {32'd2, 32'd1});
      end
    end else if (lit_mode == 3) begin
      if (cyc == 1) chk("i3_w0", data, {32'd3, 32'd0});
      if (cyc >= 2 && cyc <= 3) chk("i3_gap", 64'(vld), 64'd0);
      if (cyc == 4) begin
        chk("i3_vld1", 64'(vld), 64'd1);
        chk("i3_w1", data, {32'd3, 32'd1});
      end
    end
  endtask

  task automatic cycle(input logic r);
    @(posedge clk);
    #1 rdy = r;
    @(negedge clk);
    cyc++;
    if (m_on) model_check();
    lit_check();
  endtask

  task automatic do_reset(input logic [31:0] new_idx);
    m_on = 0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    idx = new_idx;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    cyc = 0;
    @(negedge clk);
    model_check();
    lit_check();
  endtask

  task automatic run_to_done(input bit always_rdy);
    int budget;
    budget = 2000;
    while (!m_done && budget > 0) begin
      cycle(always_rdy ? 1'b1 : 1'($urandom_range(0, 1)));
      budget--;
    end
    chk("run_timeout", 64'(m_done), 64'd1);
  endtask

  initial begin
    int w;
    m_on = 0;
    cyc = 0;
    lit_mode = 1;
    do_reset(32'd2);
    repeat (5) cycle(1'($urandom_range(0, 1)));
    w = 0;
    while (!vld && w < 50) begin
      cycle(1'b0);
      w++;
    end
    chk("bp_vld_seen", 64'(vld), 64'd1);
    repeat (10) cycle(1'b0);
    run_to_done(1'b0);
    repeat (50) cycle(1'($urandom_range(0, 1)));

    lit_mode = 2;
    do_reset(32'd2);
    run_to_done(1'b1);
    repeat (5) cycle(1'b1);

    lit_mode = 3;
    do_reset(32'd3);
    run_to_done(1'b1);
    repeat (5) cycle(1'b1);

    lit_mode = 0;
    do_reset(32'h1234_ACE1);
    run_to_done(1'b0);
    repeat (5) cycle(1'b1);

    do_reset(32'd7);
    w = 0;
    while (m_seq < 3 && w < 500) begin
      cycle(1'($urandom_range(0, 1)));
      w++;
    end
    chk("mid_seq_reached", 64'(m_seq), 64'd3);
    do_reset(32'd7);
    run_to_done(1'b0);
    repeat (20) cycle(1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
